window_scan_ctrl: RTL
=====================

# window_scan_ctrl

Raster-scan sequencer for the shift-register window extractor in the SGM datapath. It accepts a pixel stream with a start-of-frame flag and drives the window register's `enable`. It tracks column and row, and tells downstream when the extracted `block_width` x `block_height` window holds valid, non-wrapping pixels of the current frame. It also applies downstream backpressure by freezing the shift register while a window is held.

## Interface
- `frame_width`, 640, pixels per line; must match the window register.
- `frame_height`, 480, lines per frame.
- `block_width`, 1, window width; 1 ≤ block_width ≤ frame_width.
- `block_height`, 8, window height; 1 ≤ block_height ≤ frame_height.
- `x_bits`, 10, counter/coordinate width for columns; 2^x_bits ≥ frame_width.
- `y_bits`, 9, counter/coordinate width for rows; 2^y_bits ≥ frame_height.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream pixel present.
- `in_sof`  in  1  qualifies the current pixel as pixel (0,0) of a frame.
- `in_ready`  out  1  controller accepts the pixel this cycle (combinational).
- `shift_en`  out  1  drives window register `enable` (combinational).
- `win_valid`  out  1  window register contents form a valid window (registered).
- `win_ready`  in  1  downstream consumes the window this cycle.
- `win_x`  out  x_bits  left column of the valid window (registered).
- `win_y`  out  y_bits  top row of the valid window (registered).
- `frame_done`  out  1  one-cycle pulse: last pixel of the frame was shifted in.
- `err_sof`  out  1  one-cycle pulse: `in_sof` arrived mid-frame.

## Operation
- **Accept:** `accept = in_valid & in_ready`.
- **Ready:** `in_ready = ~(win_valid & ~win_ready)`. The register must not shift while an unconsumed window is held.
- **States:** IDLE and SCAN. Counters: `col` (x_bits) and `row` (y_bits) give the position of the next pixel.
- **IDLE:**
  - An accepted pixel without `in_sof` is discarded: `shift_en=0`, counters unchanged.
  - An accepted pixel with `in_sof` sets `shift_en=1`, the pixel is (0,0), and the state moves to SCAN with col=1, row=0.
- **SCAN:**
  - Every accepted pixel sets `shift_en=1`.
  - `col` increments. At col=frame_width-1 it wraps to 0 and `row` increments.
  - Accepting pixel (frame_width-1, frame_height-1) returns to IDLE with col=row=0.
- **Window qualification:** an accepted pixel at (x,y) qualifies iff x ≥ block_width-1 and y ≥ block_height-1. Windows at smaller x would straddle a line wrap and are suppressed.
- **Window register update, on the next edge:**
  - If a qualifying pixel was accepted: win_valid←1, win_x←x-(block_width-1), win_y←y-(block_height-1).
  - Else if win_ready: win_valid←0, and win_x/win_y hold.
- **Mid-frame SOF:** `in_sof` with accept in SCAN restarts the frame. The pixel becomes (0,0), counters are set to col=1, row=0, and `err_sof` pulses. Stale register contents are never exposed, because the qualification rule needs a full refill.
- **frame_done:** pulses the cycle after the last pixel is accepted, coincident with that pixel's win_valid.
- **Arithmetic:** counters are unsigned and compared against parameter-1 constants; no overflow is possible within a legal frame.

## Timing
- **Reset values:** state=IDLE, col=0, row=0, win_valid=0, win_x=0, win_y=0, frame_done=0, err_sof=0. While in reset, in_ready=1 and shift_en=in_valid&in_sof is suppressed to 0.
- **Latency:** win_valid rises exactly 1 cycle after the accepting edge of a qualifying pixel, the same edge on which the window register shifts.
- **Throughput:** 1 pixel/cycle when win_ready=1 continuously.
- **Backpressure:** win_valid=1 & win_ready=0 gives in_ready=0 and shift_en=0 in that same cycle. The window contents, win_x and win_y are frozen until win_ready.
- **Simultaneous consume and accept:** win_ready=1 with a qualifying accept in the same cycle keeps win_valid=1 and loads the new coordinates.
- **Reset mid-frame:** outputs return to reset values immediately (async), and the next frame must begin with in_sof.

## Test plan
Test parameters: frame_width=8, frame_height=6, block_width=3, block_height=3.

1. **Reset:** assert rst with in_valid=1 and in_sof=1 → in_ready=1, shift_en=0, win_valid=0, win_x=win_y=0, and no pulses.
2. **Full frame, win_ready=1:** stream 48 pixels, in_sof on the first → 48 shift_en cycles. First win_valid comes 1 cycle after pixel (2,2) (index 18) with win_x=0, win_y=0. Exactly 24 valid windows, the last at (5,3). frame_done pulses with it, then the state is IDLE.
3. **Backpressure:** win_ready=0 for 5 cycles while win_valid=1 at (1,0) → in_ready=0, shift_en=0, win_x=1/win_y=0 stable. Raise win_ready → next window (2,0) one cycle after the following accept.
4. **IDLE discard:** 4 pixels without in_sof, then an sof frame → no shift_en for the first 4, and a normal frame after.
5. **Mid-frame SOF:** in_sof on the pixel at (5,3) → err_sof pulse, no win_valid until the new frame's (2,2), and the next window is at (0,0).
6. **Async reset mid-frame:** pulse rst at (4,4) while win_valid=1 → win_valid drops without a clock. A subsequent sof frame produces 24 windows.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for the shift-register window extractor.
// Tracks pixel position, qualifies non-wrapping windows and holds them against downstream backpressure.
module window_scan_ctrl #(
  parameter int unsigned frame_width  = 640,
  parameter int unsigned frame_height = 480,
  parameter int unsigned block_width  = 1,
  parameter int unsigned block_height = 8,
  parameter int unsigned x_bits       = 10,
  parameter int unsigned y_bits       = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              in_ready,
  output logic              shift_en,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [x_bits-1:0] win_x,
  output logic [y_bits-1:0] win_y,
  output logic              frame_done,
  output logic              err_sof
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam logic [x_bits-1:0] X_LAST = x_bits'(frame_width - 1);
  localparam logic [y_bits-1:0] Y_LAST = y_bits'(frame_height - 1);
  localparam logic [x_bits-1:0] X_OFF  = x_bits'(block_width - 1);
  localparam logic [y_bits-1:0] Y_OFF  = y_bits'(block_height - 1);
  localparam logic [x_bits:0]   BW_EXT = (x_bits + 1)'(block_width);
  localparam logic [y_bits:0]   BH_EXT = (y_bits + 1)'(block_height);

  logic [0:0]        state, state_n;
  logic [x_bits-1:0] col, col_n, px, win_x_n;
  logic [y_bits-1:0] row, row_n, py, win_y_n;
  logic              win_valid_n, frame_done_n, err_sof_n;
  logic              accept, take, qual;

  // Shifting is blocked only while an unconsumed window is held.
  assign in_ready = ~(win_valid & ~win_ready);
  assign accept   = in_valid & in_ready;
  assign shift_en = take & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
      frame_done <= 1'b0;
      err_sof    <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      win_valid  <= win_valid_n;
      win_x      <= win_x_n;
      win_y      <= win_y_n;
      frame_done <= frame_done_n;
      err_sof    <= err_sof_n;
    end
  end

  always_comb begin
    state_n      = state;
    col_n        = col;
    row_n        = row;
    win_valid_n  = win_valid;
    win_x_n      = win_x;
    win_y_n      = win_y;
    frame_done_n = 1'b0;
    err_sof_n    = 1'b0;
    take         = 1'b0;
    px           = col;
    py           = row;
    qual         = 1'b0;

    case (state)
      IDLE: begin
        if (accept && in_sof) begin
          take = 1'b1;
          px   = '0;
          py   = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          take = 1'b1;
          // A mid-frame SOF restarts the scan; the refill requirement hides stale pixels.
          if (in_sof) begin
            px        = '0;
            py        = '0;
            err_sof_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      qual = (({1'b0, px} + (x_bits + 1)'(1)) >= BW_EXT) &&
             (({1'b0, py} + (y_bits + 1)'(1)) >= BH_EXT);
      if (px == X_LAST) begin
        col_n = '0;
        if (py == Y_LAST) begin
          state_n      = IDLE;
          row_n        = '0;
          frame_done_n = 1'b1;
        end else begin
          state_n = SCAN;
          row_n   = py + y_bits'(1);
        end
      end else begin
        state_n = SCAN;
        col_n   = px + x_bits'(1);
        row_n   = py;
      end
    end

    if (take && qual) begin
      win_valid_n = 1'b1;
      win_x_n     = px - X_OFF;
      win_y_n     = py - Y_OFF;
    end else if (win_ready) begin
      win_valid_n = 1'b0;
    end
  end

endmodule
